ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: the initiator side of the `idu` `reqValid`/`respValid` handshake. It holds the program counter and issues one word fetch per instruction to instruction memory. It presents the fetched word to the decoder with a one-cycle `reqValid` pulse, then holds that word until the core signals retirement and supplies the next PC. It sits between the instruction memory port and `idu`, one instruction in flight.

## Interface
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `TIMEOUT_CYCLES`, 255: memory-response watchdog limit; used only with `IFU_TIMEOUT_EN`.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_reqValid` out 1: fetch request to instruction memory, one-cycle pulse.
- `mem_addr` out 32: fetch address, equals `pc`.
- `mem_respValid` in 1: memory data valid, one-cycle pulse.
- `mem_rdata` in 32: fetched instruction word.
- `reqValid` out 1: one-cycle pulse to `idu` meaning `inst` is new.
- `inst` out 32: instruction word to `idu.inst_in`.
- `pc` out 32: PC of `inst`.
- `nextValid` in 1: current instruction retired; `pc_next` is valid.
- `pc_next` in 32: next PC from execute/writeback.
- `fault` out 1: sticky fetch-timeout flag.

## Operation
- States: IFU_IDLE, IFU_FETCH, IFU_WAIT, IFU_DONE, IFU_HOLD.
- IFU_IDLE is the reset state. It moves to IFU_FETCH unconditionally on the next cycle.
- IFU_FETCH:
  - `mem_reqValid`=1, `mem_addr`=`pc`.
  - Moves to IFU_WAIT unconditionally.
- IFU_WAIT:
  - On `mem_respValid`, `inst`<=`mem_rdata` and the state moves to IFU_DONE.
  - Otherwise the state stays in IFU_WAIT.
- IFU_DONE: `reqValid`=1 for exactly one cycle, then the state moves to IFU_HOLD.
- IFU_HOLD:
  - `inst` and `pc` are held stable, because `idu` re-samples `inst_in` every cycle.
  - On `nextValid`, `pc`<={`pc_next`[31:2],2'b00} and the state moves to IFU_FETCH.
- `mem_reqValid` and `reqValid` are decoded from the state register only (Moore outputs). There is no combinational path from any input to any output.
- `mem_respValid` outside IFU_WAIT is ignored, and `inst` is unchanged.
- `nextValid` outside IFU_HOLD is ignored, and `pc` is unchanged.
- If `nextValid` and an ignored `mem_respValid` arrive in the same cycle, only the signal valid for the current state acts.
- `pc_next` bits [1:0] are discarded; the aligned address is always fetched.
- A fetch of a PC that wraps 32'hFFFF_FFFC -> 32'h0000_0000 via `pc_next` is legal. `ifu` performs no arithmetic on `pc`.

## Timing
- Reset values:
  - state IFU_IDLE.
  - `pc`=`mem_addr`=`RESET_PC`.
  - `inst`=32'h0.
  - `mem_reqValid`=0, `reqValid`=0, `fault`=0.
- Reset asserted in any state (including IFU_WAIT) aborts the fetch and returns to IFU_IDLE next edge. The memory shares `reset`, so no stale response is expected.
- First edge after reset release: IFU_FETCH, `mem_reqValid`=1.
- A memory response arriving N cycles after the request produces `reqValid` N+1 cycles after the request.
- Minimum loop, from `nextValid` to the next `reqValid`: 3 cycles with 1-cycle memory (FETCH, WAIT, DONE).
- `idu.respValid` follows `reqValid` by 1 cycle. `ifu` does not consume it.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - A counter runs in IFU_WAIT, cleared on entry to IFU_WAIT.
  - When the counter reaches `TIMEOUT_CYCLES` without `mem_respValid`, `fault`<=1 (sticky until reset) and the state returns to IFU_FETCH to reissue the same `pc`.
  - A `mem_respValid` arriving in the same cycle the count is reached wins: no fault, and the state moves to IFU_DONE.
- `IFU_TIMEOUT_EN` undefined: no counter logic, `fault` tied 0, and IFU_WAIT waits indefinitely.

## Structure
- `ifu_defines.vh`, pulled in the same way as the other `*_defines.vh` files, holds:
  - the state encodings IFU_IDLE…IFU_HOLD;
  - the default `RESET_PC`;
  - the instruction/PC width, taken from `REG_W_END`.
- One sub-module, `ifu_watchdog` (counter, clear, limit-hit flag), instantiated only under `IFU_TIMEOUT_EN`.

## Test plan
- **Reset and first fetch:**
  - Stimulus: release reset with memory returning 32'h00500093 after 1 cycle.
  - Required: `mem_reqValid` on cycle 1 with `mem_addr`=32'h8000_0000, `reqValid` on cycle 3, `inst`=32'h00500093.
- **Redirect:**
  - Stimulus: in IFU_HOLD, `nextValid` with `pc_next`=32'h8000_0100.
  - Required: next `mem_addr`=32'h8000_0100. `inst` and `pc` stay stable until then.
- **Alignment:**
  - Stimulus: `pc_next`=32'h8000_0013.
  - Required: fetch at 32'h8000_0010.
- **Spurious inputs:**
  - Stimulus: `mem_respValid` with 32'hDEADBEEF in IFU_HOLD, and `nextValid` in IFU_WAIT.
  - Required: `inst`, `pc` and the state are all unchanged.
- **Reset mid-wait:**
  - Stimulus: assert reset in IFU_WAIT.
  - Required: the next cycle shows IFU_IDLE, `pc`=`RESET_PC`, all valids 0.
- **Timeout (`IFU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):**
  - Stimulus: no memory response.
  - Required: `fault`=1 and a reissued `mem_reqValid` at the same `mem_addr`. A response at exactly count 4 gives `fault`=0 and `reqValid`.

Source files
------------

// File: rtl/ifu_pkg.sv
// ============================================================================
// Module      : ifu_pkg
// Description : Shared widths, reset PC, state encodings and PC alignment
//               helper for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

    localparam int REG_W_END = 31;
    localparam int IFU_W     = REG_W_END + 1;

    typedef logic [IFU_W-1:0] ifu_word_t;

    localparam ifu_word_t IFU_RESET_PC = 32'h8000_0000;

    localparam int IFU_STATE_W = 3;
    typedef logic [IFU_STATE_W-1:0] ifu_state_t;

    localparam ifu_state_t IFU_IDLE  = 3'd0;
    localparam ifu_state_t IFU_FETCH = 3'd1;
    localparam ifu_state_t IFU_WAIT  = 3'd2;
    localparam ifu_state_t IFU_DONE  = 3'd3;
    localparam ifu_state_t IFU_HOLD  = 3'd4;

    // Instructions are word aligned; the low two bits of a redirect are dropped.
    function automatic ifu_word_t ifu_align(input ifu_word_t addr);
        return {addr[IFU_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_watchdog.sv
// ============================================================================
// Module      : ifu_watchdog
// Description : Memory-response watchdog; counts cycles while enabled and
//               flags when the count equals LIMIT. Used with IFU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !hit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign hit = (r_count == CNT_W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit; one fetch in flight, presents the word
//               to the decoder and holds it until retirement. Optional fetch
//               timeout watchdog enabled by defining IFU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu
    import ifu_pkg::*;
#(
    parameter ifu_word_t   RESET_PC       = IFU_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mem_reqValid,
    output logic [IFU_W-1:0] mem_addr,
    input  logic             mem_respValid,
    input  logic [IFU_W-1:0] mem_rdata,
    output logic             reqValid,
    output logic [IFU_W-1:0] inst,
    output logic [IFU_W-1:0] pc,
    input  logic             nextValid,
    input  logic [IFU_W-1:0] pc_next,
    output logic             fault
);

    ifu_state_t r_state;
    ifu_state_t w_state_next;
    ifu_word_t  r_pc;
    ifu_word_t  r_inst;
    logic       w_wd_hit;

`ifdef IFU_TIMEOUT_EN
    logic r_fault;

    ifu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (r_state != IFU_WAIT),
        .enable (r_state == IFU_WAIT),
        .hit    (w_wd_hit)
    );

    // A response in the limit cycle takes priority over the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (r_state == IFU_WAIT && !mem_respValid && w_wd_hit) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_wd_hit         = 1'b0;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IFU_IDLE:  w_state_next = IFU_FETCH;
            IFU_FETCH: w_state_next = IFU_WAIT;
            IFU_WAIT: begin
                if (mem_respValid) begin
                    w_state_next = IFU_DONE;
                end else if (w_wd_hit) begin
                    w_state_next = IFU_FETCH;
                end
            end
            IFU_DONE:  w_state_next = IFU_HOLD;
            IFU_HOLD: begin
                if (nextValid) begin
                    w_state_next = IFU_FETCH;
                end
            end
            default:   w_state_next = IFU_IDLE;
        endcase
    end

    always_comb begin
        mem_reqValid = 1'b0;
        reqValid     = 1'b0;
        case (r_state)
            IFU_FETCH: mem_reqValid = 1'b1;
            IFU_DONE:  reqValid     = 1'b1;
            default: begin
                mem_reqValid = 1'b0;
                reqValid     = 1'b0;
            end
        endcase
    end

    // Each input only acts in the state that owns it; stray pulses are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
        end else begin
            if (r_state == IFU_HOLD && nextValid) begin
                r_pc <= ifu_align(pc_next);
            end
            if (r_state == IFU_WAIT && mem_respValid) begin
                r_inst <= mem_rdata;
            end
        end
    end

    assign pc       = r_pc;
    assign mem_addr = r_pc;
    assign inst     = r_inst;

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// ============================================================================
// Module      : tb_ifu
// Description : Scoreboard bench for ifu; covers the timeout path when
//               IFU_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        reqValid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        nextValid;
    logic [31:0] pc_next;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_fetch[$];
    logic [63:0] exp_dec[$];

    ifu #(
        .RESET_PC       (32'h8000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .reqValid      (reqValid),
        .inst          (inst),
        .pc            (pc),
        .nextValid     (nextValid),
        .pc_next       (pc_next),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every fetch request and every decoder pulse must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_reqValid) begin
                if (exp_fetch.size() == 0) check("unexpected_fetch", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("fetch_addr", {32'h0, mem_addr}, {32'h0, exp_fetch.pop_front()});
            end
            if (reqValid) begin
                if (exp_dec.size() == 0) check("unexpected_reqValid", {pc, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("dec_pc_inst", {pc, inst}, exp_dec.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for the fetch pulse, returns one cycle later in the first WAIT cycle.
    task automatic expect_fetch(input logic [31:0] addr, output int cycles);
        exp_fetch.push_back(addr);
        cycles = 0;
        while (!mem_reqValid && cycles < 16) begin
            step();
            cycles++;
        end
        if (!mem_reqValid) check("fetch_timeout", 64'(cycles), 64'd0);
        step();
    endtask

    task automatic respond(input int n_wait, input logic [31:0] data, input logic [31:0] exp_pc);
        repeat (n_wait) step();
        mem_respValid = 1'b1;
        mem_rdata     = data;
        exp_dec.push_back({exp_pc, data});
        step();
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        check("reqValid_on_done", {63'h0, reqValid}, 64'd1);
        step();
    endtask

    task automatic redirect(input logic [31:0] target);
        nextValid = 1'b1;
        pc_next   = target;
        step();
        nextValid = 1'b0;
        pc_next   = 32'h0;
    endtask

    initial begin
        int cyc;
        reset         = 1'b1;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        nextValid     = 1'b0;
        pc_next       = 32'h0;
        repeat (2) step();

        check("reset_pc",       {32'h0, pc},       64'h8000_0000);
        check("reset_mem_addr", {32'h0, mem_addr}, 64'h8000_0000);
        check("reset_inst",     {32'h0, inst},     64'h0);
        check("reset_valids",   {61'h0, mem_reqValid, reqValid, fault}, 64'h0);
        reset = 1'b0;

        // Reset release and first fetch with 1-cycle memory.
        expect_fetch(32'h8000_0000, cyc);
        check("first_fetch_cycle", 64'(cyc), 64'd1);
        respond(0, 32'h0050_0093, 32'h8000_0000);

        // Stray memory response while holding.
        mem_respValid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        step();
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        step();
        check("hold_spur_inst", {32'h0, inst}, 64'h0050_0093);
        check("hold_spur_pc",   {32'h0, pc},   64'h8000_0000);
        check("hold_spur_idle", {62'h0, mem_reqValid, reqValid}, 64'h0);

        // Redirect.
        redirect(32'h8000_0100);
        check("redirect_inst_kept", {32'h0, inst}, 64'h0050_0093);
        expect_fetch(32'h8000_0100, cyc);
        respond(2, 32'h1111_1111, 32'h8000_0100);

        // Misaligned target, plus a stray retirement while waiting.
        redirect(32'h8000_0013);
        expect_fetch(32'h8000_0010, cyc);
        nextValid = 1'b1;
        pc_next   = 32'hAAAA_AAA8;
        step();
        nextValid = 1'b0;
        pc_next   = 32'h0;
        check("wait_spur_pc",    {32'h0, pc}, 64'h8000_0010);
        check("wait_spur_noreq", {62'h0, mem_reqValid, reqValid}, 64'h0);
        respond(0, 32'h2222_2222, 32'h8000_0010);

        // Top of address space, then wrap to zero with a simultaneous stray response.
        redirect(32'hFFFF_FFFF);
        expect_fetch(32'hFFFF_FFFC, cyc);
        respond(0, 32'h3333_3333, 32'hFFFF_FFFC);
        nextValid     = 1'b1;
        pc_next       = 32'h0000_0002;
        mem_respValid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        step();
        nextValid     = 1'b0;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        check("both_inst_kept", {32'h0, inst}, 64'h3333_3333);
        check("both_pc_wrap",   {32'h0, pc},   64'h0);
        expect_fetch(32'h0000_0000, cyc);
        respond(0, 32'h4444_4444, 32'h0000_0000);

        // Reset while waiting on memory.
        redirect(32'h8000_0200);
        expect_fetch(32'h8000_0200, cyc);
        reset = 1'b1;
        step();
        check("midwait_pc",     {32'h0, pc},   64'h8000_0000);
        check("midwait_inst",   {32'h0, inst}, 64'h0);
        check("midwait_valids", {61'h0, mem_reqValid, reqValid, fault}, 64'h0);
        reset = 1'b0;
        expect_fetch(32'h8000_0000, cyc);
        check("refetch_cycle", 64'(cyc), 64'd1);

        // Response in the fifth wait cycle (count 4) still completes cleanly.
        respond(4, 32'h5555_5555, 32'h8000_0000);
        check("late_resp_no_fault", {63'h0, fault}, 64'd0);

        redirect(32'h8000_0300);
        expect_fetch(32'h8000_0300, cyc);
`ifdef IFU_TIMEOUT_EN
        exp_fetch.push_back(32'h8000_0300);
        repeat (5) step();
        check("timeout_fault",   {63'h0, fault},        64'd1);
        check("timeout_reissue", {63'h0, mem_reqValid}, 64'd1);
        check("timeout_addr",    {32'h0, mem_addr},     64'h8000_0300);
        step();
        respond(0, 32'h6666_6666, 32'h8000_0300);
        check("fault_sticky", {63'h0, fault}, 64'd1);
`else
        repeat (8) step();
        check("no_timeout_fault", {63'h0, fault},        64'd0);
        check("no_timeout_wait",  {63'h0, mem_reqValid}, 64'd0);
        respond(0, 32'h6666_6666, 32'h8000_0300);
`endif

        repeat (3) step();
        check("fetch_queue_empty", 64'(exp_fetch.size()), 64'd0);
        check("dec_queue_empty",   64'(exp_dec.size()),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
